// File: rtl/el2_lsu_dccm_sched.sv
// el2_lsu_dccm_sched: single-port DCCM scheduler shared by the LSU pipe in D,
// the DMA slave and the store-buffer drain. At most one grant per cycle,
// combinational from the requests and registered starvation counters.
// Optional feature macro: RV_LSU_ARB_STARVE_EN (starvation counters present).
// Without it both counters are tied to 0, so DMA is never forced and the store
// buffer is forced only by stbuf_full.
module el2_lsu_dccm_sched #(
    parameter int unsigned DMA_STARVE_MAX   = 15,
    parameter int unsigned STBUF_STARVE_MAX = 7,
    parameter int unsigned CNT_W            = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic lsu_req_d,
    input  logic dma_req,
    input  logic stbuf_req,
    input  logic stbuf_full,
    output logic lsu_gnt,
    output logic lsu_stall,
    output logic dma_ready,
    output logic stbuf_gnt,
    output logic dccm_arb_active
);

    localparam logic [CNT_W-1:0] DMA_MAX   = CNT_W'(DMA_STARVE_MAX);
    localparam logic [CNT_W-1:0] STBUF_MAX = CNT_W'(STBUF_STARVE_MAX);

    logic [CNT_W-1:0] dma_cnt;
    logic [CNT_W-1:0] stbuf_cnt;
    logic             dma_force;
    logic             stbuf_force;
    logic             active_d;
    logic             active_q;

    // Force conditions; with counters tied to 0 dma_force is constant 0 since MAX >= 1
    always_comb begin
        dma_force   = (dma_cnt == DMA_MAX);
        stbuf_force = stbuf_full | (stbuf_cnt == STBUF_MAX);
    end

    // Fixed-priority grant: forced DMA, forced stbuf, LSU, DMA, stbuf; all off in reset
    always_comb begin
        lsu_gnt   = 1'b0;
        dma_ready = 1'b0;
        stbuf_gnt = 1'b0;
        if (!rst) begin
            if (dma_req && dma_force) begin
                dma_ready = 1'b1;
            end else if (stbuf_req && stbuf_force) begin
                stbuf_gnt = 1'b1;
            end else if (lsu_req_d) begin
                lsu_gnt = 1'b1;
            end else if (dma_req) begin
                dma_ready = 1'b1;
            end else if (stbuf_req) begin
                stbuf_gnt = 1'b1;
            end
        end
        lsu_stall = lsu_req_d & ~lsu_gnt & ~rst;
    end

`ifdef RV_LSU_ARB_STARVE_EN
    logic [CNT_W-1:0] dma_cnt_d;
    logic [CNT_W-1:0] dma_cnt_q;
    logic [CNT_W-1:0] stbuf_cnt_d;
    logic [CNT_W-1:0] stbuf_cnt_q;

    // Starvation counters: count denied cycles, saturate at MAX, clear on grant or drop
    always_comb begin
        dma_cnt_d = dma_cnt_q;
        if (!dma_req || dma_ready) begin
            dma_cnt_d = '0;
        end else if (dma_cnt_q != DMA_MAX) begin
            dma_cnt_d = dma_cnt_q + 1'b1;
        end

        stbuf_cnt_d = stbuf_cnt_q;
        if (!stbuf_req || stbuf_gnt) begin
            stbuf_cnt_d = '0;
        end else if (stbuf_cnt_q != STBUF_MAX) begin
            stbuf_cnt_d = stbuf_cnt_q + 1'b1;
        end
    end

    // Counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            dma_cnt_q   <= '0;
            stbuf_cnt_q <= '0;
        end else begin
            dma_cnt_q   <= dma_cnt_d;
            stbuf_cnt_q <= stbuf_cnt_d;
        end
    end

    assign dma_cnt   = dma_cnt_q;
    assign stbuf_cnt = stbuf_cnt_q;
`else
    assign dma_cnt   = '0;
    assign stbuf_cnt = '0;
`endif

    // Activity: any request or any pending starvation count keeps the clock enabled
    always_comb begin
        active_d = lsu_req_d | dma_req | stbuf_req | (dma_cnt != '0) | (stbuf_cnt != '0);
    end

    // Registered activity flag with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
        end else begin
            active_q <= active_d;
        end
    end

    assign dccm_arb_active = active_q;

endmodule
